// File: rtl/seg_scan_multi.sv
// seg_scan_multi: binary-to-BCD multiplexed 7-segment scanner with sign, decimal points and blink
module seg_scan_multi #(
  parameter int          DIGIT_NUM    = 6,
  parameter int          DATA_W       = 20,
  parameter logic [15:0] CNT_TIME_MAX = 16'd49_999,
  parameter logic [7:0]  BLINK_MAX    = 8'd50
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_W-1:0]    data,
  input  logic [DIGIT_NUM-1:0] point,
  input  logic                 sign,
  input  logic                 seg_en,
  input  logic [DIGIT_NUM-1:0] blink,
  output logic [DIGIT_NUM-1:0] sel,
  output logic [7:0]           seg
);
  localparam int BW = 4 * DIGIT_NUM;
  localparam int IW = $clog2(DIGIT_NUM);
  localparam int SW = $clog2(DATA_W + 1);

  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction

  localparam logic [63:0] LIM_POS = pow10(DIGIT_NUM) - 64'd1;
  localparam logic [63:0] LIM_NEG = pow10(DIGIT_NUM - 1) - 64'd1;

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        step_q, step_d;
  logic [DATA_W-1:0]    bin_q, bin_d, sat;
  logic [BW-1:0]        bcd_q, bcd_d, adj;
  logic [DIGIT_NUM-1:0] spt_q, spt_d, sbk_q, sbk_d;
  logic                 ssg_q, ssg_d;
  logic [BW-1:0]        dig_q, dig_d;
  logic [DIGIT_NUM-1:0] pt_q, pt_d, blk_q, blk_d;
  logic                 sgn_q, sgn_d;
  logic [63:0]          lim;

  // Clamping before conversion makes an overrange value come out as all nines.
  assign lim = sign ? LIM_NEG : LIM_POS;
  assign sat = ({{(64-DATA_W){1'b0}}, data} > lim) ? lim[DATA_W-1:0] : data;

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before shifting.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGIT_NUM; i++)
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Conversion FSM: sample inputs, shift DATA_W times, then load the display atomically.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    spt_d   = spt_q;
    ssg_d   = ssg_q;
    sbk_d   = sbk_q;
    dig_d   = dig_q;
    pt_d    = pt_q;
    sgn_d   = sgn_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        state_d = SHIFT;
        step_d  = '0;
        bin_d   = sat;
        bcd_d   = '0;
        spt_d   = point;
        ssg_d   = sign;
        sbk_d   = blink;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        step_d = step_q + 1'b1;
        if (step_q == SW'(DATA_W - 1)) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        dig_d   = bcd_q;
        pt_d    = spt_q;
        sgn_d   = ssg_q;
        blk_d   = sbk_q;
      end
    endcase
  end

  // Conversion and display register state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      spt_q   <= '0;
      ssg_q   <= 1'b0;
      sbk_q   <= '0;
      dig_q   <= '0;
      pt_q    <= '0;
      sgn_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      spt_q   <= spt_d;
      ssg_q   <= ssg_d;
      sbk_q   <= sbk_d;
      dig_q   <= dig_d;
      pt_q    <= pt_d;
      sgn_q   <= sgn_d;
      blk_q   <= blk_d;
    end
  end

  logic [15:0]          cnt_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           frame_q;
  logic                 phase_q;
  logic [DIGIT_NUM-1:0] sel_q;
  logic [7:0]           seg_q, code;
  logic [3:0]           hs, d, idx4;
  logic                 p, b, term, last;

  assign term = cnt_q == CNT_TIME_MAX - 16'd1;
  assign last = idx_q == IW'(DIGIT_NUM - 1);
  assign idx4 = {{(4-IW){1'b0}}, idx_q};

  // Highest shown digit (nonzero digit or point bit) and the scanned digit's fields.
  always_comb begin
    hs = '0;
    d  = '0;
    p  = 1'b0;
    b  = 1'b0;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (dig_q[4*i +: 4] != 4'd0 || pt_q[i]) hs = 4'(i);
      if (idx_q == IW'(i)) begin
        d = dig_q[4*i +: 4];
        p = pt_q[i];
        b = blk_q[i];
      end
    end
  end

  assign code = (sgn_q && idx4 == hs + 4'd1) ? 8'hBF :
                (idx4 > hs || (b && !phase_q)) ? 8'hFF :
                seg_code(d) & {~p, 7'h7F};

  // Dwell counter, digit index, frame counter and blink phase; all parked while the display is off.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b1;
    end else if (!seg_en) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else if (term) begin
      cnt_q <= '0;
      idx_q <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        frame_q <= (frame_q == BLINK_MAX - 8'd1) ? 8'd0 : frame_q + 8'd1;
        if (frame_q == BLINK_MAX - 8'd1) phase_q <= ~phase_q;
      end
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Registered digit select and segment outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q <= '0;
      seg_q <= 8'hFF;
    end else begin
      sel_q <= seg_en ? {{(DIGIT_NUM-1){1'b0}}, 1'b1} << idx_q : '0;
      seg_q <= seg_en ? code : 8'hFF;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_seg_scan_multi.sv
// tb_seg_scan_multi: scoreboard bench for the multiplexed 7-segment scanner
`timescale 1ns/1ps
module tb_seg_scan_multi;
  localparam int DN    = 6;
  localparam int DW    = 20;
  localparam int DWELL = 210;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DN-1:0] point = '0;
  logic [DN-1:0] blink = '0;
  logic          sign = 1'b0;
  logic          seg_en = 1'b0;
  logic [DN-1:0] sel;
  logic [7:0]    seg;
  int            vecs = 0;
  int            errs = 0;
  logic [13:0]   sb[$];

  always #5 clk = ~clk;

  seg_scan_multi #(
    .DIGIT_NUM(DN),
    .DATA_W(DW),
    .CNT_TIME_MAX(16'd210),
    .BLINK_MAX(8'd2)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .data(data),
    .point(point),
    .sign(sign),
    .seg_en(seg_en),
    .blink(blink),
    .sel(sel),
    .seg(seg)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    seg_en = 1'b1;
    data = 20'd42;
    sb.push_back({6'b0, 8'hFF});
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({sel, seg} !== sb[0]) begin
      errs++;
      $display("FAIL reset_state sel/seg=%h required %h", {sel, seg}, sb[0]);
    end
    void'(sb.pop_front());
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_display(input string name, input logic [DW-1:0] dv, input logic [DN-1:0] pv,
                              input logic sv, input logic [47:0] exp);
    logic [13:0] e;
    @(negedge clk);
    seg_en = 1'b0;
    data = dv;
    point = pv;
    sign = sv;
    blink = '0;
    repeat (50) @(posedge clk);
    #1;
    vecs++;
    if ({sel, seg} !== {6'b0, 8'hFF}) begin
      errs++;
      $display("FAIL %s_off sel/seg=%h required %h", name, {sel, seg}, {6'b0, 8'hFF});
    end
    @(negedge clk) seg_en = 1'b1;
    for (int k = 0; k < DN; k++) sb.push_back({6'(1 << k), exp[8*k +: 8]});
    @(posedge clk);
    for (int k = 0; k < DN; k++) begin
      repeat (k == 0 ? DWELL/2 : DWELL) @(posedge clk);
      #1;
      e = sb.pop_front();
      vecs++;
      if ({sel, seg} !== e) begin
        errs++;
        $display("FAIL %s digit%0d sel/seg=%h required %h", name, k, {sel, seg}, e);
      end
    end
  endtask

  task automatic test_seg_en();
    logic [13:0] e;
    @(negedge clk);
    seg_en = 1'b0;
    data = 20'd9876;
    point = 6'b000010;
    sign = 1'b1;
    blink = '0;
    repeat (50) @(posedge clk);
    @(negedge clk) seg_en = 1'b1;
    sb.push_back({6'b001000, 8'h90});
    sb.push_back({6'b000000, 8'hFF});
    sb.push_back({6'b000000, 8'hFF});
    @(posedge clk);
    repeat (3*DWELL + DWELL/2) @(posedge clk);
    #1;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL segen_digit3 sel/seg=%h required %h", {sel, seg}, e);
    end
    @(negedge clk) seg_en = 1'b0;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL segen_drop sel/seg=%h required %h", {sel, seg}, e);
    end
    repeat (20) @(posedge clk);
    #1;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL segen_hold sel/seg=%h required %h", {sel, seg}, e);
    end
    @(negedge clk) seg_en = 1'b1;
    for (int j = 0; j < DWELL; j++) sb.push_back({6'b000001, 8'h82});
    sb.push_back({6'b000010, 8'h78});
    @(posedge clk);
    #1;
    for (int j = 0; j <= DWELL; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      e = sb.pop_front();
      vecs++;
      if ({sel, seg} !== e) begin
        errs++;
        $display("FAIL segen_restart clk%0d sel/seg=%h required %h", j, {sel, seg}, e);
      end
    end
  endtask

  task automatic test_blink();
    logic [13:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    data = 20'd1;
    point = 6'b000010;
    sign = 1'b0;
    blink = 6'b000001;
    seg_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 6; f++) begin
      sb.push_back({6'b000001, ((f / 2) % 2 == 0) ? 8'hF9 : 8'hFF});
      sb.push_back({6'b000010, 8'h40});
      for (int k = 2; k < DN; k++) sb.push_back({6'(1 << k), 8'hFF});
      for (int k = 0; k < DN; k++) begin
        repeat ((f == 0 && k == 0) ? DWELL/2 : DWELL) @(posedge clk);
        #1;
        e = sb.pop_front();
        vecs++;
        if ({sel, seg} !== e) begin
          errs++;
          $display("FAIL blink frame%0d digit%0d sel/seg=%h required %h", f, k, {sel, seg}, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [13:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    data = 20'd654321;
    point = '0;
    sign = 1'b0;
    blink = '0;
    seg_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    sb.push_back({6'b000001, 8'hC0});
    sb.push_back({6'b000000, 8'hFF});
    repeat (10) @(posedge clk);
    #2;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL midshift_pre sel/seg=%h required %h", {sel, seg}, e);
    end
    rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL midshift_async sel/seg=%h required %h", {sel, seg}, e);
    end
    data = 20'd123457;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int j = 0; j < 22; j++) sb.push_back({6'b000001, 8'hC0});
    sb.push_back({6'b000001, 8'hF8});
    sb.push_back({6'b000010, 8'h92});
    @(posedge clk);
    for (int j = 0; j < 22; j++) begin
      if (j > 0) @(posedge clk);
      #1;
      e = sb.pop_front();
      vecs++;
      if ({sel, seg} !== e) begin
        errs++;
        $display("FAIL midshift_noparial clk%0d sel/seg=%h required %h", j, {sel, seg}, e);
      end
    end
    repeat (DWELL/2 - 21) @(posedge clk);
    #1;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL midshift_digit0 sel/seg=%h required %h", {sel, seg}, e);
    end
    repeat (DWELL) @(posedge clk);
    #1;
    e = sb.pop_front();
    vecs++;
    if ({sel, seg} !== e) begin
      errs++;
      $display("FAIL midshift_digit1 sel/seg=%h required %h", {sel, seg}, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_display("neg_point", 20'd9876, 6'b000010, 1'b1, 48'hFF_BF_90_80_78_82);
    test_display("lead_point", 20'd5, 6'b000100, 1'b0, 48'hFF_FF_FF_40_C0_92);
    test_display("sat_pos", 20'd1_000_000, 6'b000000, 1'b0, 48'h90_90_90_90_90_90);
    test_display("sat_neg", 20'd1_000_000, 6'b000000, 1'b1, 48'hBF_90_90_90_90_90);
    test_display("zero_neg", 20'd0, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_BF_C0);
    test_display("max_top_dp", 20'd999_999, 6'b100000, 1'b0, 48'h10_90_90_90_90_90);
    test_seg_en();
    test_blink();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/seg_scan_multi.md
SEG_SCAN_MULTI -- requirements
Module: seg_scan_multi

Interface
REQ-001 SHALL have parameter DIGIT_NUM, default 6, number of digits (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 20, width of the binary input (legal range 4..27).
REQ-003 SHALL have parameter CNT_TIME_MAX, default 16'd49_999, clocks per digit dwell.
REQ-004 SHALL have parameter BLINK_MAX, default 8'd50, full scan frames per blink half-period.
REQ-005 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data, input, DATA_W, unsigned magnitude to display.
REQ-008 SHALL have port point, input, DIGIT_NUM, decimal-point enable per digit (bit0 = rightmost).
REQ-009 SHALL have port sign, input, 1, 1 = show minus sign.
REQ-010 SHALL have port seg_en, input, 1, 1 = display on.
REQ-011 SHALL have port blink, input, DIGIT_NUM, blink enable per digit.
REQ-012 SHALL have port sel, output, DIGIT_NUM, one-hot active-high digit select (bit0 = rightmost).
REQ-013 SHALL have port seg, output, 8, active-low {dp,g,f,e,d,c,b,a}.

Function
REQ-014 SHALL implement a conversion FSM IDLE->SHIFT->DONE->IDLE: IDLE samples data, point, sign and blink; SHIFT performs DATA_W double-dabble steps, one per clock; DONE atomically loads the BCD digits plus the sampled point, sign and blink into the display registers; the FSM restarts immediately, giving a period of DATA_W+2 clocks.
REQ-015 SHALL make an input change visible in the display registers within 2*(DATA_W+2) clocks; no partially converted value is ever displayed.
REQ-016 SHALL saturate: if sign=0 and data>10^DIGIT_NUM-1, show all digits 9; if sign=1 and data>10^(DIGIT_NUM-1)-1, show all lower DIGIT_NUM-1 digits as 9.
REQ-017 SHALL blank leading zeros (seg=8'hFF), except that digit 0, any digit whose point bit is set, and every digit below the highest set point bit are always shown.
REQ-018 SHALL, when sign=1, display minus (8'hBF) in the position immediately left of the highest shown digit.
REQ-019 SHALL use these digit codes, 0..9: C0,F9,A4,B0,99,92,82,F8,80,90; a set point bit clears seg[7] on a shown digit only.
REQ-020 SHALL run the dwell counter 0..CNT_TIME_MAX-1; at the terminal count the digit index advances, wrapping from DIGIT_NUM-1 to 0.
REQ-021 SHALL register sel and seg, updating them one clock after the index changes.
REQ-022 SHALL count full frames (index wrap); every BLINK_MAX frames, toggle blink_phase; when blink_phase=0, a digit with its blink bit set outputs 8'hFF; the sign position never blinks.
REQ-023 SHALL, when seg_en=0, drive sel=0 and seg=8'hFF on the next clock and hold the dwell counter, index and frame counter at 0; the conversion FSM keeps running.
REQ-024 SHALL restart the scan at digit 0 when seg_en rises.

Reset
REQ-025 SHALL, on sys_rst_n=0 and without waiting for a clock edge, force sel=0, seg=8'hFF, FSM=IDLE, all counters=0, display registers=0, blink_phase=1.
REQ-026 SHALL resume scanning from digit 0 on the first clock after release, with the first valid conversion displayed after DATA_W+2 clocks.

Verification (CNT_TIME_MAX=210, DIGIT_NUM=6, DATA_W=20)
REQ-027 SHALL cover: data=9876, point=6'b000010, sign=1, seg_en=1 -> sel bit0..5 show 82, 78, 80, 90, BF, FF.
REQ-028 SHALL cover: data=5, point=6'b000100, sign=0 -> digits 0..5 show 92, C0, 40, FF, FF, FF.
REQ-029 SHALL cover: data=1_000_000, sign=0 -> all six digits 90; sign=1 -> digit5 BF, digits 0..4 90.
REQ-030 SHALL cover: seg_en dropped mid-dwell on digit 3 -> next clock sel=0, seg=FF; re-raised -> sel=6'b000001 for a full 210-clock dwell.
REQ-031 SHALL cover: BLINK_MAX=2, blink=6'b000001, data=1 -> digit0 shows F9 for 2 frames, then FF for 2 frames, repeating; other digits are unaffected.
REQ-032 SHALL cover: reset asserted in the middle of SHIFT -> sel=0, seg=FF in the same cycle; after release, the first displayed value is a fresh complete conversion.
